// File: rtl/dibit_frame_pkg.sv
// Shared definitions for the dibit frame receiver: FSM states and tag field layout.
// No logic; constants and types only.
// Imported by dibit_frame_rx and dibit_word_fifo users.
package dibit_frame_pkg;

   // Word assembly state: waiting for a start-of-word, or collecting symbols
   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // Tag field layout: d[SOF_BIT] marks start-of-word, d[SEQ_LSB +: SEQ_W] is the sequence number
   localparam int SOF_BIT = 2;
   localparam int SEQ_LSB = 0;
   localparam int SEQ_W   = 2;

   // Width of one data symbol
   localparam int SYM_W   = 2;

endpackage

// File: rtl/dibit_word_fifo.sv
// Synchronous word FIFO with full/empty flags and an occupancy counter.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push on full is ignored unless a pop happens in the same cycle.
module dibit_word_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_en;
   logic             rd_en;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);

   // A pop frees a slot in the same cycle, so push on full succeeds when paired with a pop
   assign rd_en = pop_i & ~empty_o;
   assign wr_en = push_i & (~full_o | rd_en);

   // Head is forced to zero while empty so the output never shows stale or unwritten data
   assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // Storage array; contents only matter when covered by the occupancy count
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dibit_frame_rx.sv
// Reassembles strobed 2-bit symbols into words, queues them and hands them out on valid/ready.
// Latency: a word appears on f one cycle after the edge that samples its last symbol.
// Backpressure: input side never stalls; a full FIFO without a same-cycle pop drops the word and pulses err_ovf.
// Build option: define DIBIT_FRAME_RX_SEQ_CHECK_EN to enable d[1:0] sequence-number checking.
module dibit_frame_rx
   import dibit_frame_pkg::*;
#(
   parameter int SYMS_PER_WORD = 2,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          c,
   input  logic [2:0]                    d,
   input  logic [SYM_W-1:0]              e,
   output logic [SYM_W*SYMS_PER_WORD-1:0] f,
   output logic                          f_valid,
   input  logic                          f_ready,
   output logic                          err_seq,
   output logic                          err_ovf,
   output logic                          busy
);

   localparam int W     = SYM_W * SYMS_PER_WORD;
   // Symbol index never exceeds 7 (SYMS_PER_WORD <= 8)
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYMS_PER_WORD - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     word_q;
   logic             err_seq_q;
   logic             err_ovf_q;

   logic             sof;
   logic             seq_start_ok;
   logic             seq_next_ok;
   logic             last_sym;
   logic             word_done;
   logic [W-1:0]     start_word_d;
   logic [W-1:0]     word_d;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   assign sof      = d[SOF_BIT];
   assign last_sym = (cnt_q == LAST_IDX);

`ifdef DIBIT_FRAME_RX_SEQ_CHECK_EN
   logic [SEQ_W-1:0] seq;
   assign seq          = d[SEQ_LSB +: SEQ_W];
   // Sequence number is the symbol index mod 4, so it wraps 3->0 on long words
   assign seq_start_ok = (seq == '0);
   assign seq_next_ok  = (seq == cnt_q[SEQ_W-1:0]);
`else
   // Only the start-of-word bit frames words; the sequence field is ignored
   logic unused_seq;
   assign unused_seq   = ^d[SEQ_LSB +: SEQ_W];
   assign seq_start_ok = 1'b1;
   assign seq_next_ok  = 1'b1;
`endif

   // Candidate word contents: a fresh word holding only slot 0, or the current word with slot cnt filled
   always_comb begin
      start_word_d = '0;
      start_word_d[SYM_W-1:0] = e;
      word_d = word_q;
      for (int i = 0; i < SYMS_PER_WORD; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            word_d[i*SYM_W +: SYM_W] = e;
         end
      end
   end

   // The final in-sequence symbol completes the word; it is pushed on this same edge
   assign word_done = c & (state_q == COLLECT) & ~sof & seq_next_ok & last_sym;

   assign f_valid = ~fifo_empty;
   assign pop     = f_valid & f_ready;

   // Word assembly FSM with registered busy/err_seq
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         word_q    <= '0;
         err_seq_q <= 1'b0;
      end else begin
         err_seq_q <= 1'b0;
         if (c) begin
            case (state_q)
               IDLE: begin
                  if (sof && seq_start_ok) begin
                     word_q  <= start_word_d;
                     cnt_q   <= CNT_W'(1);
                     state_q <= COLLECT;
                  end else begin
                     // Stray symbol outside a word, or a start tag with a nonzero sequence number
                     err_seq_q <= 1'b1;
                  end
               end
               COLLECT: begin
                  if (sof) begin
                     // Premature start: the partial word is abandoned
                     err_seq_q <= 1'b1;
                     if (seq_start_ok) begin
                        word_q <= start_word_d;
                        cnt_q  <= CNT_W'(1);
                     end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                     end
                  end else if (seq_next_ok) begin
                     if (last_sym) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                     end else begin
                        word_q <= word_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                     end
                  end else begin
                     err_seq_q <= 1'b1;
                     cnt_q     <= '0;
                     state_q   <= IDLE;
                  end
               end
               default: begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   // Overflow pulse: a completed word found the FIFO full with no pop to make room
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ovf_q <= 1'b0;
      end else begin
         err_ovf_q <= word_done & fifo_full & ~pop;
      end
   end

   dibit_word_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (word_done),
      .push_dat_i (word_d),
      .pop_i      (pop),
      .head_dat_o (f),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign busy    = (state_q == COLLECT);
   assign err_seq = err_seq_q;
   assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_dibit_frame_rx.sv
// Testbench for dibit_frame_rx: directed scenarios plus randomized traffic against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Model follows the framing rules on a list of collected symbols and an ordered list of queued words.
module tb_dibit_frame_rx;

   localparam int SPW   = 2;
   localparam int DEPTH = 4;
   localparam int W     = 2 * SPW;
`ifdef DIBIT_FRAME_RX_SEQ_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         c;
   logic [2:0]   d;
   logic [1:0]   e;
   logic [W-1:0] f;
   logic         f_valid;
   logic         f_ready;
   logic         err_seq;
   logic         err_ovf;
   logic         busy;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [1:0]   part[$];
   logic [W-1:0] mq[$];
   logic         m_err_seq;
   logic         m_err_ovf;

   always #5 clk = ~clk;

   dibit_frame_rx #(
      .SYMS_PER_WORD (SPW),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .c       (c),
      .d       (d),
      .e       (e),
      .f       (f),
      .f_valid (f_valid),
      .f_ready (f_ready),
      .err_seq (err_seq),
      .err_ovf (err_ovf),
      .busy    (busy)
   );

   task automatic model_reset();
      part.delete();
      mq.delete();
      m_err_seq = 1'b0;
      m_err_ovf = 1'b0;
   endtask

   // Apply one clock edge worth of framing rules to the model
   task automatic model_edge(input logic mc, input logic [2:0] md, input logic [1:0] me, input logic mr);
      bit           do_pop;
      bit           do_push;
      bit           sof;
      int           seq;
      logic [W-1:0] w;
      sof       = md[2];
      seq       = int'(md[1:0]);
      do_pop    = (mq.size() > 0) && mr;
      do_push   = 1'b0;
      w         = '0;
      m_err_seq = 1'b0;
      m_err_ovf = 1'b0;
      if (mc) begin
         if (part.size() == 0) begin
            if (sof && (!CHK || seq == 0)) part.push_back(me);
            else m_err_seq = 1'b1;
         end else if (sof) begin
            m_err_seq = 1'b1;
            part.delete();
            if (!CHK || seq == 0) part.push_back(me);
         end else if (!CHK || seq == (part.size() % 4)) begin
            part.push_back(me);
            if (part.size() == SPW) begin
               for (int i = 0; i < SPW; i++) w = w | (W'(part[i]) << (2 * i));
               do_push = 1'b1;
               part.delete();
            end
         end else begin
            m_err_seq = 1'b1;
            part.delete();
         end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         if (mq.size() < DEPTH) mq.push_back(w);
         else m_err_ovf = 1'b1;
      end
   endtask

   // Drive one cycle of input, advance model and DUT by one edge, return 1 unit after the edge
   task automatic cyc(input logic ic, input logic [2:0] id, input logic [1:0] ie);
      c = ic;
      d = id;
      e = ie;
      model_edge(ic, id, ie, f_ready);
      @(posedge clk);
      #1;
      c = 1'b0;
      d = 3'b000;
      e = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      c = 1'b0; d = 3'b000; e = 2'b00; f_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid: got %b want 0", f_valid); end
      checks++; if (f !== '0) begin errors++; $display("FAIL reset_f: got %h want 0", f); end
      checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL reset_err_seq: got %b want 0", err_seq); end
      checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_ovf: got %b want 0", err_ovf); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_clean_word();
      f_ready = 1'b1;
      cyc(1'b1, 3'b100, 2'd1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy: got %b want 1", busy); end
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL clean_early_valid: got %b want 0", f_valid); end
      cyc(1'b1, 3'b001, 2'd2);
      checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b want 1", f_valid); end
      checks++; if (f !== 4'h9) begin errors++; $display("FAIL clean_word: got %h want 9", f); end
      checks++; if (err_seq !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL clean_err: got seq=%b ovf=%b want 0 0", err_seq, err_ovf); end
      cyc(1'b0, 3'b000, 2'd0);
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL clean_one_cycle: got valid=%b want 0", f_valid); end
   endtask

   task automatic test_gapped();
      f_ready = 1'b1;
      cyc(1'b1, 3'b100, 2'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 3'b111, 2'd3);
         checks++; if (busy !== 1'b1 || err_seq !== 1'b0) begin errors++; $display("FAIL gap_hold[%0d]: got busy=%b err_seq=%b want 1 0", i, busy, err_seq); end
      end
      cyc(1'b1, 3'b001, 2'd2);
      checks++; if (f_valid !== 1'b1 || f !== 4'h9) begin errors++; $display("FAIL gap_word: got valid=%b f=%h want 1 9", f_valid, f); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_end: got %b want 0", busy); end
      cyc(1'b0, 3'b000, 2'd0);
   endtask

   task automatic test_seq_error();
      f_ready = 1'b1;
      cyc(1'b1, 3'b100, 2'd3);
      cyc(1'b1, 3'b010, 2'd0);
`ifdef DIBIT_FRAME_RX_SEQ_CHECK_EN
      checks++; if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_err_pulse: got %b want 1", err_seq); end
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL seq_err_noword: got valid=%b want 0", f_valid); end
`else
      checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL seq_ignored_pulse: got %b want 0", err_seq); end
      checks++; if (f_valid !== 1'b1 || f !== 4'h3) begin errors++; $display("FAIL seq_ignored_word: got valid=%b f=%h want 1 3", f_valid, f); end
`endif
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_busy: got %b want 0", busy); end
      cyc(1'b0, 3'b000, 2'd0);
      checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL seq_pulse_width: got %b want 0", err_seq); end
   endtask

   task automatic test_premature_start();
      f_ready = 1'b1;
      cyc(1'b1, 3'b100, 2'd1);
      cyc(1'b1, 3'b100, 2'd2);
      checks++; if (err_seq !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL premature_err: got err_seq=%b busy=%b want 1 1", err_seq, busy); end
      cyc(1'b1, 3'b001, 2'd3);
      checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL premature_once: got %b want 0", err_seq); end
      checks++; if (f_valid !== 1'b1 || f !== 4'hE) begin errors++; $display("FAIL premature_word: got valid=%b f=%h want 1 e", f_valid, f); end
      cyc(1'b0, 3'b000, 2'd0);
   endtask

   task automatic test_overflow();
      logic [3:0] kw;
      f_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         kw = 4'(k);
         cyc(1'b1, 3'b100, kw[1:0]);
         cyc(1'b1, 3'b001, kw[3:2]);
         checks++; if (err_ovf !== (k == 5)) begin errors++; $display("FAIL ovf_word%0d: got err_ovf=%b want %b", k, err_ovf, (k == 5)); end
         checks++; if (f_valid !== 1'b1 || f !== 4'h1) begin errors++; $display("FAIL ovf_hold%0d: got valid=%b f=%h want 1 1", k, f_valid, f); end
      end
      cyc(1'b0, 3'b000, 2'd0);
      checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b want 0", err_ovf); end
      f_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checks++; if (f_valid !== 1'b1 || f !== 4'(k)) begin errors++; $display("FAIL ovf_drain%0d: got valid=%b f=%h want 1 %0h", k, f_valid, f, k); end
         cyc(1'b0, 3'b000, 2'd0);
      end
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", f_valid); end
   endtask

   task automatic test_overflow_pop();
      logic [3:0] kw;
      f_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         kw = 4'(k);
         cyc(1'b1, 3'b100, kw[1:0]);
         cyc(1'b1, 3'b001, kw[3:2]);
      end
      cyc(1'b1, 3'b100, 2'd1);
      f_ready = 1'b1;
      cyc(1'b1, 3'b001, 2'd1);
      f_ready = 1'b0;
      checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovfpop_no_ovf: got %b want 0", err_ovf); end
      f_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         checks++; if (f_valid !== 1'b1 || f !== 4'(k)) begin errors++; $display("FAIL ovfpop_drain%0d: got valid=%b f=%h want 1 %0h", k, f_valid, f, k); end
         cyc(1'b0, 3'b000, 2'd0);
      end
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL ovfpop_empty: got %b want 0", f_valid); end
   endtask

   task automatic test_reset_mid();
      f_ready = 1'b0;
      cyc(1'b1, 3'b100, 2'd2);
      cyc(1'b1, 3'b001, 2'd1);
      cyc(1'b1, 3'b100, 2'd3);
      cyc(1'b1, 3'b001, 2'd1);
      cyc(1'b1, 3'b100, 2'd1);
      checks++; if (busy !== 1'b1 || f_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got busy=%b valid=%b want 1 1", busy, f_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (f_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async: got valid=%b busy=%b want 0 0", f_valid, busy); end
      model_reset();
      @(posedge clk);
      #1;
      checks++; if (err_seq !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_err: got seq=%b ovf=%b want 0 0", err_seq, err_ovf); end
      rst = 1'b0;
      f_ready = 1'b1;
      cyc(1'b1, 3'b100, 2'd3);
      cyc(1'b1, 3'b001, 2'd2);
      checks++; if (f_valid !== 1'b1 || f !== 4'hB) begin errors++; $display("FAIL rstmid_word: got valid=%b f=%h want 1 b", f_valid, f); end
      cyc(1'b0, 3'b000, 2'd0);
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rstmid_alone: got valid=%b want 0", f_valid); end
   endtask

   task automatic test_random();
      logic       ic;
      logic [2:0] id;
      logic [1:0] ie;
      for (int n = 0; n < 800; n++) begin
         ic = ($urandom_range(3) != 0);
         ie = 2'($urandom_range(3));
         if ($urandom_range(9) < 8) begin
            if (part.size() == 0) id = 3'b100;
            else id = {1'b0, 2'(part.size() % 4)};
         end else begin
            id = 3'($urandom_range(7));
         end
         if ((n % 200) < 100) f_ready = ($urandom_range(3) != 0);
         else f_ready = ($urandom_range(3) == 0);
         cyc(ic, id, ie);
         checks++; if (f_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", n, f_valid, (mq.size() > 0)); end
         if (mq.size() > 0) begin
            checks++; if (f !== mq[0]) begin errors++; $display("FAIL rand_word@%0d: got %h want %h", n, f, mq[0]); end
         end
         checks++; if (err_seq !== m_err_seq) begin errors++; $display("FAIL rand_err_seq@%0d: got %b want %b", n, err_seq, m_err_seq); end
         checks++; if (err_ovf !== m_err_ovf) begin errors++; $display("FAIL rand_err_ovf@%0d: got %b want %b", n, err_ovf, m_err_ovf); end
         checks++; if (busy !== (part.size() > 0)) begin errors++; $display("FAIL rand_busy@%0d: got %b want %b", n, busy, (part.size() > 0)); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_word();
      test_gapped();
      test_seq_error();
      test_premature_start();
      test_overflow();
      test_overflow_pop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dibit_frame_rx.md
Name: dibit_frame_rx

Overview:
- Receive-side counterpart of the symbol transmitter that drives the c/d/e bundle.
- Accepts 2-bit data symbols (e), qualified by a strobe (c) and a 3-bit tag (d).
- Reassembles the symbols into fixed-width words and buffers them in a small FIFO.
- Delivers words downstream on a valid/ready handshake, so the non-stallable input side is decoupled from a stallable consumer.

Parameters:
- SYMS_PER_WORD, 2, number of 2-bit symbols per word; word width W = 2*SYMS_PER_WORD; legal range 2..8.
- FIFO_DEPTH, 4, word FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- c  input  1  symbol strobe; d and e are valid only when c=1.
- d  input  3  tag: d[2]=start-of-word, d[1:0]=symbol sequence number mod 4.
- e  input  2  data symbol.
- f  output  W  output word; the first-received symbol occupies f[1:0].
- f_valid  output  1  f holds a word.
- f_ready  input  1  consumer accepts f when f_valid & f_ready.
- err_seq  output  1  one-cycle pulse on a framing/sequence error.
- err_ovf  output  1  one-cycle pulse when a completed word is dropped because the FIFO is full.
- busy  output  1  word assembly in progress (state COLLECT).

Behaviour:
- Reset (async assert, sync-released by the system):
  - f_valid=0, f=0, err_seq=0, err_ovf=0, busy=0.
  - FIFO empty; state IDLE; symbol counter 0.
- Input side: no backpressure. Every cycle with c=1 is one symbol; c=0 cycles are ignored and do not break a word.
- FSM states:
  - IDLE:
    - c & d[2] & d[1:0]==0: store e in slot 0, cnt=1, go to COLLECT.
    - c & !d[2]: pulse err_seq, symbol discarded, stay IDLE.
  - COLLECT:
    - c & !d[2] & d[1:0]==cnt[1:0]: store e in slot cnt, cnt++.
      - If this was symbol SYMS_PER_WORD-1: push word, go to IDLE.
    - c & d[2]: pulse err_seq, partial word dropped.
      - If d[1:0]==0: restart with e in slot 0, cnt=1, stay COLLECT.
      - Otherwise go to IDLE.
    - c & !d[2] & sequence mismatch: pulse err_seq, partial word dropped, go to IDLE.
- Sequence numbering: expected d[1:0] = symbol index mod 4, so it wraps 3->0 for SYMS_PER_WORD>4.
- Push:
  - The word enters the FIFO on the clock edge that samples the last symbol.
  - f_valid rises on the next cycle when the FIFO was empty; total latency is 1 cycle from the last-symbol edge.
- Full FIFO:
  - If the FIFO is full at push time and no pop occurs in the same cycle, the word is dropped and err_ovf pulses.
  - A simultaneous pop and push on a full FIFO succeeds with no overflow.
- Output side:
  - f/f_valid come from the FIFO head, registered.
  - Pop occurs on f_valid & f_ready.
  - f holds stable while f_valid=1 and f_ready=0.
  - f_valid deasserts when the FIFO empties.
- Error pulses: err_seq and err_ovf may pulse in the same cycle; both are registered outputs, asserted 1 cycle after the causing edge.
- Reset mid-word or with a non-empty FIFO: all content is discarded and there is no error pulse.

Optional Feature:
- Macro: DIBIT_FRAME_RX_SEQ_CHECK_EN.
- Defined: d[1:0] sequence checking exactly as above.
- Undefined:
  - d[1:0] is ignored; only d[2] frames words.
  - A mismatch never raises err_seq; err_seq still pulses on a premature start or on a stray symbol in IDLE.
  - A start-of-word always restarts regardless of d[1:0].

Decomposition:
- Shared package dibit_frame_pkg:
  - State enum (IDLE, COLLECT).
  - Tag field constants: SOF_BIT=2, SEQ_LSB=0, SEQ_W=2.
  - Symbol width constant SYM_W=2.
- One sub-module: dibit_word_fifo.
  - Parameterised width/depth synchronous FIFO with full/empty flags.
  - Occupancy counter of log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push/pop allowed when full or empty.

Test Plan:
- Clean word (defaults): symbols (d=3'b100,e=1), (d=3'b001,e=2) with f_ready=1 -> f=4'h9, f_valid high for 1 cycle, 1 cycle after the second symbol; no errors.
- Gapped input: the same two symbols with 3 idle cycles between them -> f=4'h9, busy=1 during the gap, no err_seq.
- Sequence error: (d=3'b100,e=3), (d=3'b010,e=0) -> err_seq pulse, no word, busy=0.
  - Repeat with the macro undefined -> f=4'h3, no err_seq.
- Premature start: (d=3'b100,e=1), (d=3'b100,e=2), (d=3'b001,e=3) -> err_seq once, then f=4'hE.
- Overflow: f_ready=0, send 5 clean words 0x1..0x5 -> err_ovf on the 5th; then f_ready=1 drains 0x1,0x2,0x3,0x4 in order.
  - Repeat with a pop coinciding with the 5th push -> no err_ovf.
- Reset mid-operation: assert rst after 1 symbol with 2 words queued -> f_valid=0, busy=0 immediately; the next clean word is delivered alone.
